// File: rtl/ysyx_22050612_ifu.sv
// ysyx_22050612_ifu: fetch PC, single-outstanding imem fetch and a {pc, inst} output FIFO.
// A redirect flushes the FIFO; a fetch in flight at that moment is drained and discarded.
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;
    state_t        state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [63:0]   fifo_pc_q [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];
    logic          req_fire, push, pop;
    assign imem_req_valid = !rst && state_q == S_REQ && count_q != FULL && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = count_q != '0;
    assign out_pc         = out_valid ? fifo_pc_q[head_q] : '0;
    assign out_inst       = out_valid ? fifo_inst_q[head_q] : '0;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = state_q == S_WAIT && imem_resp_valid && !redirect_valid;
    assign pop            = out_valid && out_ready && !redirect_valid;
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        head_d     = pop ? head_q + 1'b1 : head_q;
        tail_d     = push ? tail_q + 1'b1 : tail_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[63:2], 2'b00};
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            state_d    = (state_q == S_REQ || imem_resp_valid) ? S_REQ : S_DRAIN;
        end else if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 64'd4;
            state_d    = S_WAIT;
        end else if (state_q != S_REQ && imem_resp_valid) begin
            state_d = S_REQ;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end
    // Entry storage needs no reset: out_* are gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[tail_q]   <= req_pc_q;
            fifo_inst_q[tail_q] <= imem_resp_data;
        end
    end
endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// tb_ysyx_22050612_ifu: directed bench with a small instruction-memory model;
// expected {pc, inst} entries are queued by the stimulus and consumed by an output monitor.
module tb_ysyx_22050612_ifu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [63:0] out_pc;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_fail = 0;
    int n_grant = 0;
    int n_acc = 0;
    int resp_delay = 1;
    bit use_addr = 1'b0;

    assign imem_req_ready = n_acc < n_grant;

    ysyx_22050612_ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input logic [63:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Memory: accepts while grants remain, answers resp_delay cycles after acceptance.
    initial begin
        bit hs;
        bit pend;
        int dcnt;
        logic [63:0] pend_addr;
        pend = 1'b0;
        dcnt = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            hs = !rst && imem_req_valid && imem_req_ready;
            if (hs) begin
                pend = 1'b1;
                pend_addr = imem_req_addr;
                dcnt = resp_delay;
            end
            @(posedge clk);
            #1;
            if (hs) n_acc++;
            imem_resp_valid = 1'b0;
            if (rst) pend = 1'b0;
            else if (pend) begin
                if (dcnt <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data = use_addr ? {pend_addr[15:0], 16'h0013} : 32'h0010_0093;
                    pend = 1'b0;
                end else dcnt--;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got pc %h inst %h, required no entry", out_pc, out_inst);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_pc", out_pc, mon_e.pc);
                    chk("out_inst", 64'(out_inst), 64'(mon_e.inst));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        // Reset fetch
        rst = 1'b0;
        n_grant += 3;
        out_ready = 1'b1;
        expect_out(64'h8000_0000, 32'h0010_0093);
        expect_out(64'h8000_0004, 32'h0010_0093);
        expect_out(64'h8000_0008, 32'h0010_0093);
        #1;
        chk("p1_req_valid", 64'(imem_req_valid), 64'd1);
        chk("p1_addr0", imem_req_addr, 64'h8000_0000);
        tick(2);
        chk("p1_out_valid", 64'(out_valid), 64'd1);
        chk("p1_out_pc", out_pc, 64'h8000_0000);
        chk("p1_out_inst", 64'(out_inst), 64'h0010_0093);
        chk("p1_addr1", imem_req_addr, 64'h8000_0004);
        tick(2);
        chk("p1_addr2", imem_req_addr, 64'h8000_0008);
        wait_drain();
        // Backpressure
        out_ready = 1'b0;
        use_addr = 1'b1;
        n_grant += 3;
        expect_out(64'h8000_000C, 32'h000C_0013);
        expect_out(64'h8000_0010, 32'h0010_0013);
        expect_out(64'h8000_0014, 32'h0014_0013);
        tick(4);
        chk("bp_full_req_valid", 64'(imem_req_valid), 64'd0);
        chk("bp_head_pc", out_pc, 64'h8000_000C);
        tick(2);
        chk("bp_still_stalled", 64'(imem_req_valid), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp_resume_valid", 64'(imem_req_valid), 64'd1);
        chk("bp_resume_addr", imem_req_addr, 64'h8000_0014);
        chk("bp_head_after_pop", out_pc, 64'h8000_0010);
        tick(3);
        chk("bp_refull_req_valid", 64'(imem_req_valid), 64'd0);
        out_ready = 1'b1;
        wait_drain();
        // Redirect from REQ, then redirect while WAIT
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0004;
        #1;
        chk("rd_req_cut", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rd_next_valid", 64'(imem_req_valid), 64'd1);
        chk("rd_next_addr", imem_req_addr, 64'h8000_0004);
        resp_delay = 4;
        n_grant += 1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        #1;
        chk("rw_req_valid_c1", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rw_drain_c2", 64'(imem_req_valid), 64'd0);
        tick();
        chk("rw_drain_c3", 64'(imem_req_valid), 64'd0);
        tick();
        chk("rw_drain_c4", 64'(imem_req_valid), 64'd0);
        tick();
        chk("rw_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rw_req_addr", imem_req_addr, 64'h8000_0100);
        chk("rw_out_valid", 64'(out_valid), 64'd0);
        // Redirect with simultaneous response and pop
        resp_delay = 1;
        n_grant += 2;
        out_ready = 1'b0;
        tick(3);
        chk("rs_pre_out_valid", 64'(out_valid), 64'd1);
        chk("rs_pre_out_pc", out_pc, 64'h8000_0100);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0300;
        out_ready = 1'b1;
        #1;
        chk("rs_req_cut", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rs_out_valid", 64'(out_valid), 64'd0);
        chk("rs_out_pc", out_pc, 64'd0);
        chk("rs_out_inst", 64'(out_inst), 64'd0);
        chk("rs_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rs_req_addr", imem_req_addr, 64'h8000_0300);
        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0203;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("mis_req_addr", imem_req_addr, 64'h8000_0200);
        n_grant += 1;
        expect_out(64'h8000_0200, 32'h0200_0013);
        wait_drain();
        // Wrap-around, then reset while WAIT
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wr_addr_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        n_grant += 1;
        tick(2);
        chk("wr_out_valid", 64'(out_valid), 64'd1);
        chk("wr_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_out_inst", 64'(out_inst), 64'hFFFC_0013);
        chk("wr_addr_zero", imem_req_addr, 64'd0);
        resp_delay = 3;
        n_grant += 1;
        tick();
        rst = 1'b1;
        #1;
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_out_pc", out_pc, 64'd0);
        chk("mr_out_inst", 64'(out_inst), 64'd0);
        chk("mr_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_next_valid", 64'(imem_req_valid), 64'd1);
        chk("mr_next_addr", imem_req_addr, 64'h8000_0000);
        resp_delay = 1;
        n_grant += 1;
        out_ready = 1'b1;
        expect_out(64'h8000_0000, 32'h0000_0013);
        wait_drain();
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
